// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - Wishbone classic master for single load/store accesses.
// Checks alignment, drives one size-encoded cycle, returns extended load data or an error.
`ifndef WB_M2S
`define WB_M2S [70:0]
`endif
`ifndef WB_S2M
`define WB_S2M [32:0]
`endif

module wb_lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_req,
  input  logic           i_we,
  input  logic [1:0]     i_size,
  input  logic           i_unsigned,
  input  logic [31:0]    i_addr,
  input  logic [31:0]    i_wdata,
  output logic           o_ready,
  output logic           o_done,
  output logic           o_err,
  output logic [1:0]     o_err_code,
  output logic [31:0]    o_rdata,
  output logic `WB_M2S   o_m2s_wb,
  input  logic `WB_S2M   i_s2m_wb
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        cyc_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  sel_q;
  logic [15:0] cnt_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  code_q;
  logic [31:0] rdata_q;

  logic        ack;
  logic [31:0] bus_rdata;

  assign ack       = i_s2m_wb[0];
  assign bus_rdata = i_s2m_wb[32:1];

  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] size_sel(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {24'd0, d[7:0]};
      2'b01:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                         input logic [31:0] d);
    case (size)
      2'b00:   return {{24{~uns & d[7]}}, d[7:0]};
      2'b01:   return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      sel_q   <= 4'd0;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req) begin
            we_q   <= i_we;
            size_q <= i_size;
            uns_q  <= i_unsigned;
            addr_q <= i_addr;
            data_q <= lane_mask(i_size, i_wdata);
            sel_q  <= size_sel(i_size);
            cnt_q  <= 16'd0;
            if (misaligned(i_size, i_addr)) begin
              // Rejected before any bus activity.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              code_q  <= 2'b01;
              rdata_q <= 32'd0;
            end else begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
            end
          end
        end
        BUS: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (ack) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            rdata_q <= we_q ? 32'd0 : extend(size_q, uns_q, bus_rdata);
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            code_q  <= 2'b10;
            rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          code_q  <= 2'b00;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_rdata    = rdata_q;
  // {addr, data, sel, we, stb, cyc}; stb and cyc share one register.
  assign o_m2s_wb   = {addr_q, data_q, sel_q, we_q, cyc_q, cyc_q};

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - directed self-checking bench for wb_lsu_master.
`ifndef WB_M2S
`define WB_M2S [70:0]
`endif
`ifndef WB_S2M
`define WB_S2M [32:0]
`endif

module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, done, err;
  logic [1:0]  code;
  logic [31:0] rdata;
  logic `WB_M2S m2s;
  logic `WB_S2M s2m;

  logic        slave_en = 1'b1;
  int          slave_waits = 0;
  logic        force_ack = 1'b0;
  logic [31:0] slave_rdata = 32'd0;
  int          ws_cnt = 0;
  logic        ack;

  logic        cyc, stb, bwe;
  logic [3:0]  bsel;
  logic [31:0] bdata, baddr;

  int errors = 0;
  int checks = 0;

  int          r_cyc, r_done_k;
  logic        r_err, r_we, r_stb_bad, r_ready_done;
  logic [1:0]  r_code;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata, r_addr, r_bdata;

  wb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .o_ready(ready),
    .o_done(done), .o_err(err), .o_err_code(code), .o_rdata(rdata),
    .o_m2s_wb(m2s), .i_s2m_wb(s2m)
  );

  always #5 clk = ~clk;

  assign cyc   = m2s[0];
  assign stb   = m2s[1];
  assign bwe   = m2s[2];
  assign bsel  = m2s[6:3];
  assign bdata = m2s[38:7];
  assign baddr = m2s[70:39];

  always @(posedge clk) ws_cnt <= cyc ? ws_cnt + 1 : 0;
  assign ack = force_ack | (slave_en & cyc & (ws_cnt == slave_waits));
  assign s2m = {slave_rdata, ack};

  // Issue one request and watch until o_done; k counts negedges after the sampling edge.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    r_cyc = 0; r_done_k = 0; r_stb_bad = 1'b0;
    r_sel = 4'd0; r_we = 1'b0; r_addr = 32'd0; r_bdata = 32'd0;
    for (int k = 1; k <= 40 && r_done_k == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (cyc !== stb) r_stb_bad = 1'b1;
      if (cyc === 1'b1) begin
        if (r_cyc == 0) begin
          r_sel = bsel; r_we = bwe; r_addr = baddr; r_bdata = bdata;
        end
        r_cyc++;
      end
      if (done === 1'b1) begin
        r_done_k = k; r_err = err; r_code = code; r_rdata = rdata; r_ready_done = ready;
        if (cyc !== 1'b0) r_stb_bad = 1'b1;
      end
    end
    checks++;
    if (r_done_k == 0) begin
      errors++; $display("FAIL done_wait got no o_done within 40 cycles required one");
    end
    checks++;
    if (r_stb_bad) begin
      errors++; $display("FAIL cyc_stb got cyc!=stb or cyc high in DONE required equal/low");
    end
  endtask

  task automatic test_reset;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || code !== 2'b00 || rdata !== 32'd0) begin
      errors++; $display("FAIL reset_outs got ready=%b done=%b err=%b code=%b rdata=%h required 1 0 0 00 0",
                         ready, done, err, code, rdata);
    end
    checks++;
    if (m2s !== 71'd0) begin
      errors++; $display("FAIL reset_bus got %h required 0", m2s);
    end
    req = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || cyc !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b cyc=%b required 1 0", ready, cyc);
    end
  endtask

  task automatic test_store_word;
    slave_en = 1'b1; slave_waits = 0;
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    checks++;
    if (r_cyc != 1 || r_sel !== 4'b1111 || r_we !== 1'b1 || r_addr !== 32'h100 || r_bdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_bus got cyc=%0d sel=%b we=%b addr=%h data=%h required 1 1111 1 100 deadbeef",
                         r_cyc, r_sel, r_we, r_addr, r_bdata);
    end
    checks++;
    if (r_done_k != 2 || r_err !== 1'b0 || r_rdata !== 32'd0 || r_ready_done !== 1'b0) begin
      errors++; $display("FAIL store_done got k=%0d err=%b rdata=%h ready=%b required 2 0 0 0",
                         r_done_k, r_err, r_rdata, r_ready_done);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL store_after got ready=%b done=%b required 1 0", ready, done);
    end
  endtask

  task automatic test_load_byte;
    slave_rdata = 32'h000000EF;
    run_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFFFFEF || r_sel !== 4'b0001 || r_we !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL lb_signed got rdata=%h sel=%b we=%b err=%b required ffffffef 0001 0 0",
                         r_rdata, r_sel, r_we, r_err);
    end
    run_access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    checks++;
    if (r_rdata !== 32'h000000EF || r_sel !== 4'b0001) begin
      errors++; $display("FAIL lb_unsigned got rdata=%h sel=%b required 000000ef 0001", r_rdata, r_sel);
    end
    run_access(1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD);
    checks++;
    if (r_bdata !== 32'h000000DD || r_sel !== 4'b0001 || r_addr !== 32'h103 || r_rdata !== 32'd0) begin
      errors++; $display("FAIL sb_lanes got data=%h sel=%b addr=%h rdata=%h required 000000dd 0001 103 0",
                         r_bdata, r_sel, r_addr, r_rdata);
    end
  endtask

  task automatic test_load_half;
    slave_rdata = 32'h00008001;
    run_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFF8001 || r_sel !== 4'b0011 || r_addr !== 32'h102) begin
      errors++; $display("FAIL lh_signed got rdata=%h sel=%b addr=%h required ffff8001 0011 102",
                         r_rdata, r_sel, r_addr);
    end
    slave_rdata = 32'hFFFF7FFE;
    run_access(1'b0, 2'b01, 1'b1, 32'h0, 32'h0);
    checks++;
    if (r_rdata !== 32'h00007FFE) begin
      errors++; $display("FAIL lhu got rdata=%h required 00007ffe", r_rdata);
    end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz_t [3];
    logic [31:0] a_t [3];
    sz_t[0] = 2'b01; a_t[0] = 32'h101;
    sz_t[1] = 2'b10; a_t[1] = 32'h102;
    sz_t[2] = 2'b11; a_t[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, sz_t[i], 1'b0, a_t[i], 32'h0);
      checks++;
      if (r_cyc != 0 || r_done_k != 1 || r_err !== 1'b1 || r_code !== 2'b01 || r_rdata !== 32'd0) begin
        errors++; $display("FAIL misalign_%0d got cyc=%0d k=%0d err=%b code=%b rdata=%h required 0 1 1 01 0",
                           i, r_cyc, r_done_k, r_err, r_code, r_rdata);
      end
    end
  endtask

  task automatic test_wait_states;
    slave_waits = 3; slave_rdata = 32'h12345678;
    run_access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    checks++;
    if (r_cyc != 4 || r_done_k != 5 || r_rdata !== 32'h12345678 || r_err !== 1'b0) begin
      errors++; $display("FAIL wait3 got cyc=%0d k=%0d rdata=%h err=%b required 4 5 12345678 0",
                         r_cyc, r_done_k, r_rdata, r_err);
    end
    slave_waits = 7; slave_rdata = 32'h0BADF00D;
    run_access(1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
    checks++;
    if (r_cyc != 8 || r_err !== 1'b0 || r_code !== 2'b00 || r_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL ack_at_limit got cyc=%0d err=%b code=%b rdata=%h required 8 0 00 0badf00d",
                         r_cyc, r_err, r_code, r_rdata);
    end
    slave_waits = 0;
  endtask

  task automatic test_timeout;
    int late_done;
    slave_en = 1'b0;
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    checks++;
    if (r_cyc != 8 || r_done_k != 9 || r_err !== 1'b1 || r_code !== 2'b10 || r_rdata !== 32'd0) begin
      errors++; $display("FAIL timeout got cyc=%0d k=%0d err=%b code=%b rdata=%h required 8 9 1 10 0",
                         r_cyc, r_done_k, r_err, r_code, r_rdata);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL timeout_ready got %b required 1", ready);
    end
    force_ack = 1'b1;
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || cyc === 1'b1) late_done++;
    end
    force_ack = 1'b0;
    checks++;
    if (late_done != 0) begin
      errors++; $display("FAIL late_ack got %0d cycles with done/cyc required 0", late_done);
    end
    slave_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    int n_cyc, n_done, bad_addr;
    n_cyc = 0; n_done = 0; bad_addr = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h400; wdata = 32'h11112222;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cyc === 1'b1) begin
        n_cyc++;
        if (baddr !== 32'h400) bad_addr++;
      end
      if (done === 1'b1) n_done++;
      if (k == 1) addr = 32'h500;
      if (k == 2) req = 1'b0;
    end
    checks++;
    if (n_cyc != 1 || n_done != 1 || bad_addr != 0) begin
      errors++; $display("FAIL dropped_req got cyc=%0d done=%0d badaddr=%0d required 1 1 0",
                         n_cyc, n_done, bad_addr);
    end
  endtask

  task automatic test_reset_mid_access;
    int seen_done;
    seen_done = 0;
    slave_en = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h600;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (cyc !== 1'b1) begin
      errors++; $display("FAIL mid_cyc got %b required 1", cyc);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0) begin
      errors++; $display("FAIL async_drop got cyc=%b stb=%b required 0 0", cyc, stb);
    end
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0 || ready !== 1'b1) begin
      errors++; $display("FAIL reset_lost got done_count=%0d ready=%b required 0 1", seen_done, ready);
    end
    slave_en = 1'b1; slave_waits = 0; slave_rdata = 32'hCAFEF00D;
    run_access(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    checks++;
    if (r_done_k != 2 || r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL post_reset got k=%0d err=%b rdata=%h required 2 0 cafef00d",
                         r_done_k, r_err, r_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_misaligned();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone master bridge between the core's memory stage and the on-chip RAM/bus. Sits directly upstream of the RAM slave.
- Takes one load/store request at a time from the pipeline and checks alignment.
- Runs a single Wishbone classic cycle using size-encoded sel with right-justified data.
- Returns sign/zero-extended load data, or an error if the access is misaligned or the bus times out.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles cyc/stb may stay high without ack before the access aborts with a bus error (1..65535).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_req  in  1  request valid; accepted only when o_ready=1.
- i_we  in  1  1=store, 0=load.
- i_size  in  2  00=byte, 01=half, 10=word, 11=invalid.
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-justified.
- o_ready  out  1  bridge idle, can accept a request.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  qualifies o_done: access failed.
- o_err_code  out  2  00=none, 01=misaligned/invalid size, 10=bus timeout.
- o_rdata  out  32  extended load data, valid while o_done=1.
- o_m2s_wb  out  `WB_M2S  master-to-slave bundle (addr, data, sel, we, stb, cyc).
- i_s2m_wb  in  `WB_S2M  slave-to-master bundle (data, ack).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset:
  - state=IDLE; cyc, stb, we = 0; addr, data, sel = 0; o_done, o_err = 0; o_err_code=00; o_rdata=0; timeout counter=0.
  - o_ready=1. o_ready is decoded from state; requests are ignored while i_rstn=0.
- Reset mid-access: cyc/stb drop asynchronously. The access is lost and no o_done is issued.
- States: IDLE, BUS, DONE.
- IDLE:
  - o_ready=1.
  - On i_req sampled high: latch we, size, unsigned, addr, wdata.
  - Invalid size, half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with o_err=1, code 01, and no bus cycle.
  - Otherwise -> BUS.
- BUS:
  - Registered outputs: cyc=stb=1; addr=i_addr unmodified; we=latched we.
  - sel = 0001 for byte, 0011 for half, 1111 for word.
  - Write data = latched wdata, right-justified, unused lanes 0.
  - Counter increments each BUS cycle with ack=0.
  - ack sampled high -> capture read data, clear cyc/stb at the same edge -> DONE with o_err=0.
  - Counter reaches TIMEOUT_CYCLES with no ack -> clear cyc/stb -> DONE with o_err=1, code 10.
- DONE:
  - o_done=1 for exactly one cycle, o_ready=0, then -> IDLE.
  - Store or error: o_rdata=0.
- Load extension:
  - byte uses bus data[7:0], extended from bit 7.
  - half uses bus data[15:0], extended from bit 15.
  - word is passed through.
- Latency with a zero-wait slave (combinational ack):
  - request sampled at edge E0; cyc high E0–E1; ack sampled at E1; o_done high E1–E2; o_ready high again after E2.
  - 3 cycles per access.
  - Each slave wait state adds 1 cycle.
- Boundary cases:
  - ack while in IDLE or DONE is ignored.
  - i_req while o_ready=0 is dropped, not queued.
  - ack in the same cycle the counter hits TIMEOUT_CYCLES: ack wins, giving a normal completion.
  - The counter clears on every entry to BUS.
  - cyc and stb are always equal. Neither is ever high in IDLE or DONE.

Test Plan:
- Store word 0xDEADBEEF to 0x100, zero-wait slave -> cyc/stb high 1 cycle, sel=1111, we=1, addr=0x100, o_done 1 cycle later with o_err=0, o_rdata=0.
- Load byte from 0x100 with i_unsigned=0, slave data 0x000000EF -> o_rdata=0xFFFFFFEF; repeat with i_unsigned=1 -> 0x000000EF, sel=0001.
- Load half from 0x102 with slave data 0x00008001, signed -> sel=0011, o_rdata=0xFFFF8001; half from 0x101 -> o_done+o_err, code 01, cyc never asserted.
- Slave with 3 wait states, word load 0x12345678 -> cyc high 4 cycles, o_done 5 cycles after request, o_rdata=0x12345678.
- TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles, o_done+o_err, code 10, o_ready returns next cycle; a later ack is ignored.
- Assert i_rstn low while in BUS -> cyc/stb fall without waiting for a clock edge, no o_done; after release o_ready=1 and a new request completes normally.
